// File: rtl/pipeline_collect.sv
// pipeline_collect
// ----------------
// Join stage for N independent valid/ready producer lanes. Each lane
// deposits one item into its own holding register, in any order and at any
// time. Once every lane holds an item, the N items leave together as one
// combined beat on a single valid/ready output.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      synchronous, active-high reset; clears every lane
//   i_valid  [N]        lane i offers i_data[i]
//   i_ready  [N]        lane i may be accepted this cycle
//   i_data   [N][DW]    per-lane payload
//   o_valid             combined beat available
//   o_ready             consumer accepts the combined beat
//   o_data   [N*DW]     lane i occupies bits [i*DW +: DW]

module pipeline_collect #(
    parameter int N  = 2,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      i_valid,
    output logic [N-1:0]      i_ready,
    input  logic [DW-1:0]     i_data [N],
    output logic              o_valid,
    input  logic              o_ready,
    output logic [N*DW-1:0]   o_data
);

    logic [N-1:0]  held;
    logic [DW-1:0] lane_buf [N];
    logic          fire;

    // The beat is complete only once every lane has delivered; this depends
    // on registered state alone, never on the incoming valids.
    assign o_valid = &held;
    assign fire    = o_valid & o_ready;

    // A lane slot is free when empty, or when it is being emptied by a fire
    // on this very edge. The o_ready -> i_ready path is what allows one beat
    // per cycle when every lane streams.
    assign i_ready = rst ? '0 : (~held | {N{fire}});

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_out
            assign o_data[g*DW +: DW] = lane_buf[g];
        end
    endgenerate

    // A capture on the fire edge wins over the clear, so the new item stays
    // held and belongs to the next beat. Reset discards partial collections.
    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
            for (int i = 0; i < N; i++) begin
                lane_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_valid[i] && i_ready[i]) begin
                    lane_buf[i] <= i_data[i];
                    held[i]     <= 1'b1;
                end else if (fire) begin
                    held[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_collect.sv
// tb_pipeline_collect
// -------------------
// Drives two instances of pipeline_collect: a N=2/DW=32 instance through
// hand-written scenarios, and a N=4/DW=8 instance with random valid/ready
// traffic. A queue-per-lane model tracks accepted-but-not-emitted items and
// predicts o_valid, i_ready and o_data every cycle for both instances.

module tb_pipeline_collect;

    logic        clk;
    logic        rst2;
    logic [1:0]  i_valid2;
    logic [1:0]  i_ready2;
    logic [31:0] i_data2 [2];
    logic        o_valid2;
    logic        o_ready2;
    logic [63:0] o_data2;

    logic        rst4;
    logic [3:0]  i_valid4;
    logic [3:0]  i_ready4;
    logic [7:0]  i_data4 [4];
    logic        o_valid4;
    logic        o_ready4;
    logic [31:0] o_data4;

    int checks = 0;
    int errors = 0;
    int beats4 = 0;

    pipeline_collect #(.N(2), .DW(32)) dut2 (
        .clk     (clk),
        .rst     (rst2),
        .i_valid (i_valid2),
        .i_ready (i_ready2),
        .i_data  (i_data2),
        .o_valid (o_valid2),
        .o_ready (o_ready2),
        .o_data  (o_data2)
    );

    pipeline_collect #(.N(4), .DW(8)) dut4 (
        .clk     (clk),
        .rst     (rst4),
        .i_valid (i_valid4),
        .i_ready (i_ready4),
        .i_data  (i_data4),
        .o_valid (o_valid4),
        .o_ready (o_ready4),
        .o_data  (o_data4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
        i_valid2   = v;
        i_data2[0] = d0;
        i_data2[1] = d1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: each lane keeps a queue of items it has handed over
    // that have not yet left in a beat. A beat is offered while every queue
    // is non-empty, and it carries the front of each queue.
    // ------------------------------------------------------------------
    logic [31:0] m2 [2][$];
    logic [7:0]  m4 [4][$];
    bit          live2 = 0;
    bit          live4 = 0;

    logic        ev2, ef2, ev4, ef4;
    logic [1:0]  er2;
    logic [3:0]  er4;
    logic [63:0] ed2;
    logic [31:0] ed4;

    always @(negedge clk) begin
        ev2 = 1'b0; ef2 = 1'b0; er2 = '0; ed2 = '0;
        ev4 = 1'b0; ef4 = 1'b0; er4 = '0; ed4 = '0;

        if (live2) begin
            ev2 = (m2[0].size() > 0) && (m2[1].size() > 0);
            ef2 = ev2 && o_ready2;
            for (int i = 0; i < 2; i++) er2[i] = !rst2 && ((m2[i].size() == 0) || ef2);
            checkOutput("o_valid2", {63'd0, o_valid2}, {63'd0, ev2});
            checkOutput("i_ready2", {62'd0, i_ready2}, {62'd0, er2});
            if (ev2) begin
                ed2 = {m2[1][0], m2[0][0]};
                checkOutput("o_data2", o_data2, ed2);
            end
        end
        if (rst2) begin
            for (int i = 0; i < 2; i++) m2[i].delete();
            live2 = 1;
        end else if (live2) begin
            if (ef2) for (int i = 0; i < 2; i++) void'(m2[i].pop_front());
            for (int i = 0; i < 2; i++) if (i_valid2[i] && er2[i]) m2[i].push_back(i_data2[i]);
        end

        if (live4) begin
            ev4 = 1'b1;
            for (int i = 0; i < 4; i++) if (m4[i].size() == 0) ev4 = 1'b0;
            ef4 = ev4 && o_ready4;
            for (int i = 0; i < 4; i++) er4[i] = !rst4 && ((m4[i].size() == 0) || ef4);
            checkOutput("o_valid4", {63'd0, o_valid4}, {63'd0, ev4});
            checkOutput("i_ready4", {60'd0, i_ready4}, {60'd0, er4});
            if (ev4) begin
                for (int i = 0; i < 4; i++) ed4[i*8 +: 8] = m4[i][0];
                checkOutput("o_data4", {32'd0, o_data4}, {32'd0, ed4});
            end
        end
        if (rst4) begin
            for (int i = 0; i < 4; i++) m4[i].delete();
            live4 = 1;
        end else if (live4) begin
            if (ef4) begin
                beats4++;
                for (int i = 0; i < 4; i++) void'(m4[i].pop_front());
            end
            for (int i = 0; i < 4; i++) if (i_valid4[i] && er4[i]) m4[i].push_back(i_data4[i]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with hand-computed literal expectations for the N=2 block,
    // followed by random traffic on the N=4 block.
    // ------------------------------------------------------------------
    initial begin
        rst2 = 1'b1; o_ready2 = 1'b0;
        applyStimulus(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
        rst4 = 1'b1; o_ready4 = 1'b0; i_valid4 = '0;
        for (int i = 0; i < 4; i++) i_data4[i] = '0;

        // Reset with lanes offering: nothing accepted, nothing presented
        repeat (2) begin
            tick();
            @(negedge clk);
            checkOutput("rst_i_ready", {62'd0, i_ready2}, 64'd0);
            checkOutput("rst_o_valid", {63'd0, o_valid2}, 64'd0);
        end
        tick();
        rst2 = 1'b0;
        applyStimulus(2'b00, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("post_rst_i_ready", {62'd0, i_ready2}, 64'd3);
        checkOutput("post_rst_o_valid", {63'd0, o_valid2}, 64'd0);

        // Out-of-order collection: lane1 first, lane0 three cycles later
        tick();
        applyStimulus(2'b10, 32'd0, 32'hBBBB_0001);
        tick();
        applyStimulus(2'b00, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("ooo_o_valid_partial", {63'd0, o_valid2}, 64'd0);
        checkOutput("ooo_i_ready_partial", {62'd0, i_ready2}, 64'd1);
        tick();
        tick();
        applyStimulus(2'b01, 32'hAAAA_0000, 32'd0);
        tick();
        applyStimulus(2'b00, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("ooo_o_valid", {63'd0, o_valid2}, 64'd1);
        checkOutput("ooo_o_data", o_data2, 64'hBBBB_0001_AAAA_0000);

        // Backpressure: lanes re-offer while the beat is stalled
        tick();
        applyStimulus(2'b11, 32'h1, 32'h2);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_i_ready", {62'd0, i_ready2}, 64'd0);
            checkOutput("bp_o_data", o_data2, 64'hBBBB_0001_AAAA_0000);
            tick();
        end
        o_ready2 = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_i_ready", {62'd0, i_ready2}, 64'd3);
        tick();
        applyStimulus(2'b11, 32'd0, 32'd100);
        @(negedge clk);
        checkOutput("bp_new_beat", o_data2, 64'h0000_0002_0000_0001);

        // Streaming: one beat per cycle, lanes paired in order
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 9) applyStimulus(2'b00, 32'd0, 32'd0);
            else        applyStimulus(2'b11, k + 1, 100 + k + 1);
            @(negedge clk);
            checkOutput("stream_o_valid", {63'd0, o_valid2}, 64'd1);
            checkOutput("stream_o_data", o_data2, {32'(100 + k), 32'(k)});
        end
        tick();
        @(negedge clk);
        checkOutput("stream_drained", {63'd0, o_valid2}, 64'd0);

        // Reset in the middle of a partial collection
        tick();
        o_ready2 = 1'b0;
        applyStimulus(2'b01, 32'h55, 32'd0);
        tick();
        applyStimulus(2'b00, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("mid_partial_i_ready", {62'd0, i_ready2}, 64'd2);
        tick();
        rst2 = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_i_ready", {62'd0, i_ready2}, 64'd0);
        tick();
        rst2 = 1'b0;
        @(negedge clk);
        checkOutput("mid_after_o_valid", {63'd0, o_valid2}, 64'd0);
        checkOutput("mid_after_i_ready", {62'd0, i_ready2}, 64'd3);
        tick();
        applyStimulus(2'b11, 32'h77, 32'h66);
        tick();
        applyStimulus(2'b00, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("mid_beat_valid", {63'd0, o_valid2}, 64'd1);
        checkOutput("mid_beat_data", o_data2, 64'h0000_0066_0000_0077);
        tick();
        o_ready2 = 1'b1;
        tick();
        o_ready2 = 1'b0;
        @(negedge clk);
        checkOutput("mid_beat_gone", {63'd0, o_valid2}, 64'd0);

        // Random traffic on the four-lane instance
        for (int c = 0; c < 10000; c++) begin
            tick();
            rst4     = (c > 0) && ($urandom_range(0, 499) == 0);
            i_valid4 = 4'($urandom_range(0, 15));
            o_ready4 = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) i_data4[i] = 8'($urandom_range(0, 255));
        end
        tick();
        i_valid4 = '0;
        @(negedge clk);
        checkOutput("rand_beats_seen", {63'd0, beats4 > 500}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
